// File: rtl/mem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM state codes, CPU access
// types, owner codes and the alignment rule for CPU accesses.
package mem_arb_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_ISSUE = 3'd1;
    localparam logic [2:0] ST_RD_DATA  = 3'd2;
    localparam logic [2:0] ST_WR_ISSUE = 3'd3;
    localparam logic [2:0] ST_ERR      = 3'd4;

    localparam logic [1:0] TYPE_WORD   = 2'b00;
    localparam logic [1:0] TYPE_HALF_S = 2'b01;
    localparam logic [1:0] TYPE_BYTE_S = 2'b10;
    localparam logic [1:0] TYPE_BYTE_U = 2'b11;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DBG = 1'b1;

    // Words must be 4-byte aligned, halves 2-byte aligned; bytes never fault.
    function automatic logic is_misaligned(input logic [1:0] acc_type,
                                           input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (acc_type)
            TYPE_WORD:   bad = (lane != 2'b00);
            TYPE_HALF_S: bad = lane[0];
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/subword_unit.sv
// Big-endian byte-lane logic: extracts a sign/zero-extended load value from a
// memory word and merges right-justified store data into the addressed lanes.
module subword_unit
    import mem_arb_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [1:0]  acc_type,
    input  logic [31:0] wdata,
    output logic [31:0] merged,
    output logic [31:0] extracted
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        byte_sel = word[31:24];
        case (addr)
            2'd0: byte_sel = word[31:24];
            2'd1: byte_sel = word[23:16];
            2'd2: byte_sel = word[15:8];
            2'd3: byte_sel = word[7:0];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr[1] ? word[15:0] : word[31:16];
    end

    always_comb begin
        extracted = word;
        case (acc_type)
            TYPE_HALF_S: extracted = {{16{half_sel[15]}}, half_sel};
            TYPE_BYTE_S: extracted = {{24{byte_sel[7]}}, byte_sel};
            TYPE_BYTE_U: extracted = {24'h0, byte_sel};
            default:     extracted = word;
        endcase
    end

    always_comb begin
        merged = wdata;
        case (acc_type)
            TYPE_HALF_S: merged = addr[1] ? {word[31:16], wdata[15:0]}
                                          : {wdata[15:0], word[15:0]};
            TYPE_BYTE_S, TYPE_BYTE_U: begin
                case (addr)
                    2'd0: merged = {wdata[7:0], word[23:0]};
                    2'd1: merged = {word[31:24], wdata[7:0], word[15:0]};
                    2'd2: merged = {word[31:16], wdata[7:0], word[7:0]};
                    2'd3: merged = {word[31:8], wdata[7:0]};
                    default: merged = word;
                endcase
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates a CPU MEM-stage port and a word-only debug/loader port onto one
// synchronous-read word memory, with bounded debug starvation and sub-word RMW.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_type,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic [2:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic [CW-1:0] starve_q, starve_d;
    logic [31:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [1:0]    type_q, type_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   cpu_rdata_q, cpu_rdata_d;
    logic [31:0]   dbg_rdata_q, dbg_rdata_d;

    logic [31:0] merged, extracted;
    logic        cpu_grant, dbg_grant, ack_now;

    subword_unit u_subword (
        .word      (mem_rdata),
        .addr      (addr_q[1:0]),
        .acc_type  (type_q),
        .wdata     (wdata_q),
        .merged    (merged),
        .extracted (extracted)
    );

    assign cpu_grant = cpu_req && (!dbg_req || (starve_q < STARVE_LIM));
    assign dbg_grant = !cpu_grant && dbg_req;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        we_d        = we_q;
        type_d      = type_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_grant) begin
                    owner_d = OWNER_CPU;
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    type_d  = cpu_type;
                    wdata_d = cpu_wdata;
                    if (is_misaligned(cpu_type, cpu_addr[1:0]))
                        state_d = ST_ERR;
                    else if (cpu_we && (cpu_type == TYPE_WORD))
                        state_d = ST_WR_ISSUE;
                    else
                        state_d = ST_RD_ISSUE;
                end else if (dbg_grant) begin
                    owner_d = OWNER_DBG;
                    addr_d  = dbg_addr;
                    we_d    = dbg_we;
                    type_d  = TYPE_WORD;
                    wdata_d = dbg_wdata;
                    state_d = dbg_we ? ST_WR_ISSUE : ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: state_d = ST_RD_DATA;
            ST_RD_DATA: begin
                // A sub-word store reuses the read path, then writes the merged word.
                if (we_q) begin
                    wdata_d = merged;
                    state_d = ST_WR_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                    if (owner_q == OWNER_CPU)
                        cpu_rdata_d = extracted;
                    else
                        dbg_rdata_d = mem_rdata;
                end
            end
            ST_WR_ISSUE: state_d = ST_IDLE;
            ST_ERR: begin
                cpu_rdata_d = 32'h0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if ((state_q == ST_IDLE) && cpu_grant && dbg_req) begin
            if (starve_q != STARVE_LIM)
                starve_d = starve_q + CW'(1);
        end else if (!dbg_req || ((state_q == ST_IDLE) && dbg_grant)) begin
            starve_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWNER_CPU;
            starve_q    <= '0;
            addr_q      <= 32'h0;
            we_q        <= 1'b0;
            type_q      <= TYPE_WORD;
            wdata_q     <= 32'h0;
            cpu_rdata_q <= 32'h0;
            dbg_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            type_q      <= type_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Strobes and acks decode from registered state; read data passes through in RD_DATA.
    always_comb begin
        ack_now   = ((state_q == ST_RD_DATA) && !we_q) || (state_q == ST_WR_ISSUE) ||
                    (state_q == ST_ERR);
        cpu_ack   = ack_now && (owner_q == OWNER_CPU);
        dbg_ack   = ack_now && (owner_q == OWNER_DBG);
        cpu_err   = (state_q == ST_ERR) && (owner_q == OWNER_CPU);
        mem_re    = (state_q == ST_RD_ISSUE);
        mem_we    = (state_q == ST_WR_ISSUE);
        mem_addr  = (state_q != ST_IDLE) ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_wdata = mem_we ? wdata_q : 32'h0;
        cpu_rdata = cpu_rdata_q;
        dbg_rdata = dbg_rdata_q;
        if ((state_q == ST_RD_DATA) && !we_q) begin
            if (owner_q == OWNER_CPU)
                cpu_rdata = extracted;
            else
                dbg_rdata = mem_rdata;
        end else if (state_q == ST_ERR) begin
            cpu_rdata = 32'h0;
        end
        cpu_stall = cpu_req && !cpu_ack;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive CPU grants allowed while dbg_req is pending.
REQ-002 SHALL have port Clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port cpu_req, input, 1: MEM-stage access request; held with all cpu_* fields stable until cpu_ack.
REQ-005 SHALL have port cpu_we, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port cpu_addr, input, 32: byte address.
REQ-007 SHALL have port cpu_wdata, input, 32: store data, right-justified for sub-word.
REQ-008 SHALL have port cpu_type, input, 2: 00 word, 01 half signed, 10 byte signed, 11 byte unsigned.
REQ-009 SHALL have ports cpu_ack (output, 1), cpu_err (output, 1), cpu_rdata (output, 32), cpu_stall (output, 1).
REQ-010 SHALL have ports dbg_req, dbg_we (input, 1), dbg_addr, dbg_wdata (input, 32), dbg_ack (output, 1), dbg_rdata (output, 32): word-only debug/loader port.
REQ-011 SHALL have ports mem_addr, mem_wdata (output, 32), mem_we, mem_re (output, 1), mem_rdata (input, 32): word memory, synchronous read, data valid one cycle after mem_re.

Function
REQ-012 SHALL implement FSM states IDLE, RD_ISSUE, RD_DATA, WR_ISSUE, ERR.
REQ-013 IDLE SHALL grant CPU if cpu_req and (not dbg_req or starve_cnt < STARVE_MAX), else DBG if dbg_req; grant latched into owner register.
REQ-014 starve_cnt SHALL increment on a CPU grant while dbg_req=1, clear on a DBG grant or when dbg_req=0, and saturate at STARVE_MAX.
REQ-015 Word load: IDLE -> RD_ISSUE (mem_re=1) -> RD_DATA (ack=1, rdata=mem_rdata) -> IDLE; ack 2 cycles after grant edge.
REQ-016 Word store: IDLE -> WR_ISSUE (mem_we=1, ack=1) -> IDLE.
REQ-017 Sub-word store: IDLE -> RD_ISSUE -> RD_DATA (merge, no ack) -> WR_ISSUE (mem_we=1 with merged word, ack=1) -> IDLE; only addressed lanes change.
REQ-018 Byte lanes SHALL be big-endian: offset 0 = bits[31:24]; half at addr[1]=0 = bits[31:16].
REQ-019 Sub-word loads SHALL extract the addressed lane, sign-extended for types 01/10, zero-extended for 11.
REQ-020 mem_addr SHALL be {addr[31:2], 2'b00} of the owner while busy, 0 in IDLE.
REQ-021 Misaligned CPU access (word with addr[1:0]!=0, half with addr[0]=1) SHALL go IDLE -> ERR: cpu_ack=1, cpu_err=1, cpu_rdata=0, no mem_re/mem_we.
REQ-022 dbg_addr[1:0] SHALL be ignored; dbg never raises err.
REQ-023 ack/err SHALL be single-cycle pulses to the owner only; rdata SHALL hold until the owner's next ack.
REQ-024 cpu_stall SHALL equal cpu_req AND NOT cpu_ack (combinational).
REQ-025 mem_we and mem_re SHALL never be asserted in the same cycle; both SHALL decode from registered state only.
REQ-026 After any ack, FSM SHALL return to IDLE; back-to-back requests are re-arbitrated (minimum one IDLE cycle).

Reset
REQ-027 Reset low SHALL immediately force state=IDLE, starve_cnt=0, owner=CPU, all outputs 0 except cpu_stall (= cpu_req).
REQ-028 An access in flight at reset SHALL be dropped with no ack and no further mem_we.

Structure
REQ-029 State encoding and cpu_type codes SHALL live in shared package mem_arb_pkg.
REQ-030 Lane merge/extract SHALL be a combinational sub-module subword_unit (inputs word, addr[1:0], type, wdata; outputs merged, extracted).

Verification
REQ-031 CPU lw 0x0000_0010, mem returns 0x1122_3344 -> mem_re cycle 1, cpu_ack and rdata=0x1122_3344 cycle 2.
REQ-032 CPU sb 0xAB at 0x0000_0013 over 0x1122_3344 -> mem_we cycle 3 with 0x1122_33AB, ack same cycle.
REQ-033 CPU lb at 0x...11 over 0x1180_3344 -> rdata=0xFFFF_FF80; type 11 -> 0x0000_0080.
REQ-034 CPU lw at 0x0000_0012 -> cpu_err pulse cycle 1, no memory strobes.
REQ-035 cpu_req and dbg_req held continuously -> grant order CPU x4, DBG, CPU x4, DBG.
REQ-036 Reset asserted in RD_DATA of a sub-word store -> no mem_we, no ack, IDLE after release.
